// File: rtl/iob_mem_arbiter_pkg.sv
// rtl/iob_mem_arbiter_pkg.sv - state encoding and bus field offsets for iob_mem_arbiter
package iob_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    // Response bus {rdata, rvalid, ready}, MSB first
    localparam int RESP_READY_OFF  = 0;
    localparam int RESP_RVALID_OFF = 1;
    localparam int RESP_RDATA_OFF  = 2;

    // Request bus {avalid, addr, wdata, wstrb}, MSB first
    localparam int REQ_WSTRB_OFF = 0;

    function automatic int req_wdata_off(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int req_addr_off(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int req_avalid_off(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_arb_prio2.sv
// rtl/iob_arb_prio2.sv - 2-requester picker; IOB_MEM_ARBITER_RR_EN selects round-robin ties
module iob_arb_prio2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef IOB_MEM_ARBITER_RR_EN
    // on a tie, serve the slot that was not served last (last=1 means slot 1)
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // fixed priority: slot 1 (dbus) wins every tie
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/iob_mem_arbiter.sv
// rtl/iob_mem_arbiter.sv - two-master IOb arbiter onto one slave; IOB_MEM_ARBITER_RR_EN enables round-robin
module iob_mem_arbiter
    import iob_mem_arbiter_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    localparam int WSTRB_W = DATA_W / 8,
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
    localparam int RESP_W  = DATA_W + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*REQ_W-1:0]  m_req,
    output logic [2*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]    s_req,
    input  logic [RESP_W-1:0]   s_resp,
    output logic [1:0]          grant
);

    localparam int AVALID_OFF = req_avalid_off(ADDR_W, DATA_W);

    arb_state_t        state;
    logic              owner;
    logic              last;
    logic [1:0]        avalids;
    logic [1:0]        pick;
    logic [REQ_W-1:0]  own_req;
    logic              own_write;
    logic [RESP_W-1:0] own_resp;
    logic              s_ready;
    logic              s_rvalid;
    logic [DATA_W-1:0] s_rdata;

    assign avalids   = {m_req[REQ_W + AVALID_OFF], m_req[AVALID_OFF]};
    assign own_req   = owner ? m_req[REQ_W +: REQ_W] : m_req[0 +: REQ_W];
    assign own_write = |own_req[REQ_WSTRB_OFF +: WSTRB_W];
    assign s_ready   = s_resp[RESP_READY_OFF];
    assign s_rvalid  = s_resp[RESP_RVALID_OFF];
    assign s_rdata   = s_resp[RESP_RDATA_OFF +: DATA_W];

    iob_arb_prio2 u_prio (
        .req  (avalids),
        .last (last),
        .gnt  (pick)
    );

`ifdef IOB_MEM_ARBITER_RR_EN
    // remember the slot granted most recently; starts at slot 1 so slot 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (state == IDLE && |avalids) begin
            last <= pick[1];
        end
    end
`else
    assign last = 1'b1;
`endif

    // one transaction at a time: grant, wait for slave ready, then for read data if it was a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (|avalids) begin
                        owner <= pick[1];
                        grant <= pick;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (s_ready) begin
                        if (own_write) begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (s_rvalid) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // forward the owner's request to the slave and the slave's response to the owner only
    always_comb begin
        s_req    = '0;
        own_resp = '0;
        m_resp   = '0;
        case (state)
            REQ: begin
                s_req                    = own_req;
                own_resp[RESP_READY_OFF] = s_ready;
            end
            RDATA: begin
                own_resp[RESP_RDATA_OFF +: DATA_W] = s_rdata;
                own_resp[RESP_RVALID_OFF]          = s_rvalid;
            end
            default: begin
            end
        endcase
        if (state != IDLE) begin
            if (owner) begin
                m_resp[RESP_W +: RESP_W] = own_resp;
            end else begin
                m_resp[0 +: RESP_W] = own_resp;
            end
        end
    end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// tb/tb_iob_mem_arbiter.sv - self-checking bench for iob_mem_arbiter (honours IOB_MEM_ARBITER_RR_EN)
module tb_iob_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WSTRB_W = DATA_W / 8;
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W;
    localparam int RESP_W  = DATA_W + 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2*REQ_W-1:0]  m_req = '0;
    logic [2*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]    s_req;
    logic [RESP_W-1:0]   s_resp = '0;
    logic [1:0]          grant;

    int n_checks = 0;
    int n_fail   = 0;

    iob_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp),
        .grant  (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic av, input logic [31:0] a,
                                                 input logic [31:0] wd, input logic [3:0] ws);
        return {av, a, wd, ws};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] rd, input logic rv, input logic rdy);
        return {rd, rv, rdy};
    endfunction

    function automatic logic [RESP_W-1:0] slot_resp(input int i);
        return m_resp[i*RESP_W +: RESP_W];
    endfunction

    function automatic int tie_winner(input int last_served);
`ifdef IOB_MEM_ARBITER_RR_EN
        return (last_served == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // transaction-level model state for the random phase
    int              cur;
    bit              acc;
    int              last_srv;
    bit              m_act   [2];
    logic [31:0]     m_addr  [2];
    logic [31:0]     m_wdata [2];
    logic [3:0]      m_wstrb [2];
    logic [31:0]     ref_mem [16];
    logic [31:0]     slv_mem [16];
    logic [31:0]     exp_rd;
    int              s_wait;
    bit              rd_pend;
    int              r_wait;
    logic [31:0]     rd_data;

    initial begin
        logic [REQ_W-1:0]  rq0;
        logic [REQ_W-1:0]  rq1;
        logic [1:0]        eg;
        logic              s_rdy;
        logic              s_rv;
        logic [31:0]       s_rd;
        logic [RESP_W-1:0] er;
        int                w;
        int                n;

        // reset state
        #2;
        check("rst_grant", grant, 2'b00);
        check("rst_s_req", s_req, '0);
        check("rst_m_resp", m_resp, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single ibus read at 0x100
        @(negedge clk);
        rq0 = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
        m_req = {{REQ_W{1'b0}}, rq0};
        #1 check("rd_t0_s_req", s_req, '0);
        @(negedge clk);
        s_resp = mk_resp(32'h0, 1'b0, 1'b1);
        #1 check("rd_t1_s_req", s_req, rq0);
        check("rd_t1_grant", grant, 2'b01);
        check("rd_t1_resp0", slot_resp(0), mk_resp(32'h0, 1'b0, 1'b1));
        check("rd_t1_resp1", slot_resp(1), '0);
        @(negedge clk);
        m_req  = '0;
        s_resp = mk_resp(32'hDEADBEEF, 1'b1, 1'b0);
        #1 check("rd_t2_resp0", slot_resp(0), mk_resp(32'hDEADBEEF, 1'b1, 1'b0));
        check("rd_t2_resp1", slot_resp(1), '0);
        check("rd_t2_avalid", s_req[REQ_W-1], 1'b0);
        @(negedge clk);
        s_resp = '0;
        #1 check("rd_t3_grant", grant, 2'b00);

        // both masters read every time: tie arbitration four times from reset
        rst = 1'b1;
        rq0 = mk_req(1'b1, 32'h200, 32'h0, 4'h0);
        rq1 = mk_req(1'b1, 32'h204, 32'h0, 4'h0);
        m_req = {rq1, rq0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_srv = 1;
        for (int k = 0; k < 4; k++) begin
            w  = tie_winner(last_srv);
            eg = (w == 0) ? 2'b01 : 2'b10;
            n  = 0;
            @(negedge clk);
            #1;
            while (grant == 2'b00 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("tie_grant", grant, eg);
            last_srv = w;
            s_resp = mk_resp(32'h0, 1'b0, 1'b1);
            @(negedge clk);
            m_req[w*REQ_W + REQ_W - 1] = 1'b0;
            s_resp = mk_resp(32'hA0 + k, 1'b1, 1'b0);
            #1 check("tie_rdata", slot_resp(w), mk_resp(32'hA0 + k, 1'b1, 1'b0));
            check("tie_other", slot_resp(1 - w), '0);
            @(negedge clk);
            s_resp = '0;
            m_req[w*REQ_W + REQ_W - 1] = 1'b1;
        end
        @(negedge clk);
        m_req = '0;
        do_reset();

        // reset while the read data is outstanding, then a late rvalid
        @(negedge clk);
        m_req = {mk_req(1'b1, 32'h300, 32'h0, 4'h0), {REQ_W{1'b0}}};
        @(negedge clk);
        s_resp = mk_resp(32'h0, 1'b0, 1'b1);
        @(negedge clk);
        m_req  = '0;
        s_resp = '0;
        #1 check("rdata_grant", grant, 2'b10);
        rst = 1'b1;
        #1 check("arst_grant", grant, 2'b00);
        check("arst_s_req", s_req, '0);
        check("arst_m_resp", m_resp, '0);
        @(negedge clk);
        rst = 1'b0;
        s_resp = mk_resp(32'h12345678, 1'b1, 1'b0);
        #1 check("late_rv_m_resp", m_resp, '0);
        check("late_rv_grant", grant, 2'b00);
        @(negedge clk);
        s_resp = '0;

        // random traffic against the transaction-level model
        do_reset();
        cur = -1; acc = 1'b0; last_srv = 1;
        s_wait = -1; rd_pend = 1'b0; r_wait = 0; rd_data = '0; exp_rd = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i] && cur != i) begin
                    if ($urandom % 4 == 0) begin
                        m_act[i]   = 1'b1;
                        m_addr[i]  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
                        m_wstrb[i] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                        m_wdata[i] = $urandom;
                    end
                end else if (m_act[i] && cur != i && $urandom % 16 == 0) begin
                    m_act[i] = 1'b0;
                end
            end
            rq0 = mk_req(m_act[0], m_addr[0], m_wdata[0], m_wstrb[0]);
            rq1 = mk_req(m_act[1], m_addr[1], m_wdata[1], m_wstrb[1]);
            m_req = {rq1, rq0};
            #1;
            s_rdy = 1'b0;
            s_rv  = 1'b0;
            s_rd  = $urandom;
            if (rd_pend) begin
                if (r_wait == 0) begin
                    s_rv = 1'b1;
                    s_rd = rd_data;
                end
            end else begin
                s_rv = ($urandom % 8 == 0);
            end
            if (s_req[REQ_W-1]) begin
                if (s_wait < 0) s_wait = ($urandom % 6 == 0) ? 10 : int'($urandom_range(0, 3));
                s_rdy = (s_wait == 0);
            end else begin
                s_wait = -1;
                s_rdy  = ($urandom % 8 == 0);
            end
            s_resp = mk_resp(s_rd, s_rv, s_rdy);
            #1;
            eg = (cur < 0) ? 2'b00 : ((cur == 0) ? 2'b01 : 2'b10);
            check("rnd_grant", grant, eg);
            check("rnd_s_req", s_req, (cur >= 0 && !acc) ? ((cur == 0) ? rq0 : rq1) : '0);
            for (int i = 0; i < 2; i++) begin
                er = '0;
                if (cur == i) er = acc ? mk_resp(s_rd, s_rv, 1'b0) : mk_resp(32'h0, 1'b0, s_rdy);
                check("rnd_m_resp", slot_resp(i), er);
            end
            // slave side bookkeeping from what it actually received
            if (s_req[REQ_W-1] && s_rdy) begin
                s_wait = -1;
                if (s_req[WSTRB_W-1:0] != 0) begin
                    for (int b = 0; b < 4; b++)
                        if (s_req[b]) slv_mem[s_req[WSTRB_W+DATA_W+2 +: 4]][8*b +: 8] = s_req[WSTRB_W + 8*b +: 8];
                end else begin
                    rd_pend = 1'b1;
                    rd_data = slv_mem[s_req[WSTRB_W+DATA_W+2 +: 4]];
                    r_wait  = $urandom_range(0, 2);
                end
            end else if (s_req[REQ_W-1] && s_wait > 0) begin
                s_wait--;
            end else if (rd_pend) begin
                if (s_rv) rd_pend = 1'b0;
                else if (r_wait > 0) r_wait--;
            end
            // transaction model
            if (cur < 0) begin
                if (m_act[0] || m_act[1]) begin
                    cur = (m_act[0] && m_act[1]) ? tie_winner(last_srv) : (m_act[1] ? 1 : 0);
                    last_srv = cur;
                    acc = 1'b0;
                end
            end else if (!acc) begin
                if (s_rdy) begin
                    if (m_wstrb[cur] != 0) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[cur][b]) ref_mem[m_addr[cur][5:2]][8*b +: 8] = m_wdata[cur][8*b +: 8];
                        m_act[cur] = 1'b0;
                        cur = -1;
                    end else begin
                        exp_rd = ref_mem[m_addr[cur][5:2]];
                        m_act[cur] = 1'b0;
                        acc = 1'b1;
                    end
                end
            end else if (s_rv) begin
                er = slot_resp(cur);
                check("rnd_rdata", er[RESP_W-1:2], exp_rd);
                cur = -1;
                acc = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
